font_rom_arb: RTL

- Two-requester round-robin arbiter that shares one synchronous font ROM read port (11-bit address, 8-bit line data) between two text overlay stages running on the 40 MHz pixel clock.
- Captures the winning address, drives the ROM and tracks in-flight reads with a tag pipeline.
- Steers returned line data to the requester that issued it, with a per-requester valid strobe.
- Sits between two character-drawing stages and the font ROM, so a second text box can be added without a second ROM.

---
 rtl/font_rom_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/font_rom_arb.sv
// -----------------------------------------------------------------------------
// font_rom_arb
//
// Round-robin arbiter that lets two text overlay stages share one synchronous
// font ROM read port. The winning address is registered onto rom_addr. A small
// tag pipeline follows each read through the ROM. The returned character line
// is then steered back to the requester that issued it.
//
// Ports
//   clk       pixel clock (40 MHz)
//   rst       asynchronous reset, active low
//   req0/1    read request; held high with addr stable until the matching gnt
//   addr0/1   ROM address {char_code[6:0], char_line[3:0]}
//   gnt0/1    one-cycle pulse: the requester's address has been captured
//   valid0/1  one-cycle pulse: data0/1 holds the line for a granted read
//   data0/1   returned line data; holds its value between valid pulses
//   rom_addr  registered address to the font ROM
//   rom_data  font ROM read data, ROM_LAT cycles after rom_addr changes
//
// Parameters
//   ADDR_W   ROM address width
//   DATA_W   ROM data width
//   ROM_LAT  ROM read latency in clk cycles (1..4)
// -----------------------------------------------------------------------------
module font_rom_arb #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              valid0,
  output logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              valid1,
  output logic [DATA_W-1:0] data1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  // A requester is masked in the cycle its grant is showing. A request held
  // across that cycle is not counted twice, so a lone requester gets at most
  // one grant every two cycles.
  logic elig0;
  logic elig1;
  logic contested;
  logic win0;
  logic win1;

  // 0: requester 0 preferred on the next contested edge, 1: requester 1.
  logic pref1;

  assign elig0     = req0 & ~gnt0;
  assign elig1     = req1 & ~gnt1;
  assign contested = elig0 & elig1;
  assign win0      = elig0 & (~elig1 | ~pref1);
  assign win1      = elig1 & (~elig0 |  pref1);

  // ---------------------------------------------------------------------------
  // Arbitration and ROM address register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      pref1    <= 1'b0;
      rom_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples pre-edge values, whatever order the simulator runs the blocks.
      gnt0 <= win0;
      gnt1 <= win1;
      if (win0) begin
        rom_addr <= addr0;
      end else if (win1) begin
        rom_addr <= addr1;
      end
      // Preference only moves when both requesters actually competed.
      if (contested) begin
        pref1 <= ~pref1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: stage 0 is loaded at the grant edge. Stage ROM_LAT lines up
  // with the cycle in which rom_data carries the line for that grant.
  // ---------------------------------------------------------------------------
  logic [ROM_LAT:0] tag_vld;
  logic [ROM_LAT:0] tag_id;
  logic             ret0;
  logic             ret1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the tag pipeline is cleared on reset on purpose. A read issued
      // before reset must never surface as a valid pulse after release.
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[ROM_LAT-1:0], win0 | win1};
      tag_id  <= {tag_id[ROM_LAT-1:0], win1};
    end
  end

  assign ret0 = tag_vld[ROM_LAT] & ~tag_id[ROM_LAT];
  assign ret1 = tag_vld[ROM_LAT] &  tag_id[ROM_LAT];

  // ---------------------------------------------------------------------------
  // Return steering: each data register changes only on its own returns.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      data0  <= '0;
      data1  <= '0;
    end else begin
      valid0 <= ret0;
      valid1 <= ret1;
      if (ret0) begin
        data0 <= rom_data;
      end
      if (ret1) begin
        data1 <= rom_data;
      end
    end
  end

endmodule
